// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: next-PC formation and one-at-a-time imem fetch sequencing.
// Ports: clk/rst (sync, active-high); stall; br_valid/br_taken/br_offset/br_pc4;
//   jmp_valid/jmp_index; imem_req/imem_addr/imem_ack; pc_out/pc4_out/inst_valid; flush.
// Build option: BRANCH_DELAY_SLOT_EN keeps the decode-side instruction on a redirect.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_valid,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] br_pc4,
  input  logic              jmp_valid,
  input  logic [25:0]       jmp_index,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc4_out,
  output logic              inst_valid,
  output logic              flush
);

  typedef enum logic [1:0] {
    S_RST,
    S_REQ,
    S_DRAIN
  } state_t;

  localparam logic [ADDR_W-1:0] INC = 4;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              skid_vld_q, skid_vld_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              out_vld_q, out_vld_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;
  logic              flush_q, flush_d;

  logic              redirect;
  logic              ack_ok;
  logic              accept;
  logic [ADDR_W-1:0] target;

  assign redirect = jmp_valid | (br_valid & br_taken);
  assign ack_ok   = req_q & imem_ack;
  assign target   = jmp_valid ?
                    {br_pc4[ADDR_W-1:ADDR_W-4], jmp_index, 2'b00} :
                    br_pc4 + br_offset;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    skid_vld_d = skid_vld_q;
    skid_pc_d  = skid_pc_q;
    out_vld_d  = out_vld_q;
    out_pc_d   = out_pc_q;
    out_pc4_d  = out_pc4_q;
    flush_d    = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      S_RST: begin
        state_d = S_REQ;
        if (!redirect) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end
      end
      S_REQ: begin
        if (ack_ok) begin
          pc_d   = pc_q + INC;
          accept = ~redirect;
        end else if (req_q && redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The ack here belongs to the stale address; it is dropped.
        if (ack_ok) begin
          state_d = S_REQ;
          req_d   = 1'b0;
        end
      end
      default: state_d = S_RST;
    endcase

    if (redirect) begin
      pc_d       = target;
      skid_vld_d = 1'b0;
      // An open, un-acked request must stay on the bus (drain).
      req_d      = req_q & ~ack_ok;
`ifdef BRANCH_DELAY_SLOT_EN
      // Decode-side instruction is the delay slot: keep it, no squash.
      flush_d    = 1'b0;
`else
      out_vld_d  = 1'b0;
      flush_d    = 1'b1;
`endif
    end else begin
      if (!stall) begin
        if (skid_vld_q) begin
          out_vld_d  = 1'b1;
          out_pc_d   = skid_pc_q;
          out_pc4_d  = skid_pc_q + INC;
          skid_vld_d = 1'b0;
        end else if (accept) begin
          out_vld_d  = 1'b1;
          out_pc_d   = addr_q;
          out_pc4_d  = addr_q + INC;
        end else begin
          out_vld_d  = 1'b0;
        end
      end else if (accept) begin
        skid_vld_d = 1'b1;
        skid_pc_d  = addr_q;
      end
      // Back-to-back issue: a new request may open on the ack edge.
      if (state_q == S_REQ && (!req_q || ack_ok)) begin
        req_d  = ~skid_vld_d;
        addr_d = pc_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RST;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      addr_q     <= RESET_VECTOR;
      skid_vld_q <= 1'b0;
      skid_pc_q  <= '0;
      out_vld_q  <= 1'b0;
      out_pc_q   <= '0;
      out_pc4_q  <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      skid_vld_q <= skid_vld_d;
      skid_pc_q  <= skid_pc_d;
      out_vld_q  <= out_vld_d;
      out_pc_q   <= out_pc_d;
      out_pc4_q  <= out_pc4_d;
      flush_q    <= flush_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign pc_out     = out_pc_q;
  assign pc4_out    = out_pc4_q;
  assign inst_valid = out_vld_q;
  assign flush      = flush_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios for pc_fetch_unit.
// Expected values are hand-computed per scenario.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_offset;
  logic [31:0] br_pc4;
  logic        jmp_valid;
  logic [25:0] jmp_index;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] pc_out;
  logic [31:0] pc4_out;
  logic        inst_valid;
  logic        flush;

  int total = 0;
  int bad   = 0;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic RFL = 1'b0;
`else
  localparam logic RFL = 1'b1;
`endif

  pc_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_valid(br_valid), .br_taken(br_taken),
    .br_offset(br_offset), .br_pc4(br_pc4),
    .jmp_valid(jmp_valid), .jmp_index(jmp_index),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .pc_out(pc_out),
    .pc4_out(pc4_out), .inst_valid(inst_valid),
    .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_redir();
    br_valid  = 1'b0;
    br_taken  = 1'b0;
    jmp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; stall = 1'b0;
    tick(); tick();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_out); end
    total++; if (pc4_out !== 32'h0) begin bad++; $display("FAIL rst_pc4 got=%h exp=0", pc4_out); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_vld got=%h exp=0", inst_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%h exp=0", flush); end
    rst = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL t1_req got=%h exp=1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL t1_addr got=%h exp=0", imem_addr); end
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL t1_vld0 got=%h exp=0", inst_valid); end
    tick();
    total++; if (pc_out !== 32'h0 || inst_valid !== 1'b1) begin bad++; $display("FAIL t1_pc0 got=%h/%h exp=0/1", pc_out, inst_valid); end
    total++; if (pc4_out !== 32'h4) begin bad++; $display("FAIL t1_pc4 got=%h exp=4", pc4_out); end
    tick();
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL t1_pc1 got=%h exp=4", pc_out); end
    tick();
    total++; if (pc_out !== 32'h8) begin bad++; $display("FAIL t1_pc2 got=%h exp=8", pc_out); end
    total++; if (imem_addr !== 32'hC) begin bad++; $display("FAIL t1_addr3 got=%h exp=c", imem_addr); end
  endtask

  task automatic test_stall_skid();
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    imem_ack = 1'b1;
    tick(); tick();
    total++; if (pc_out !== 32'h4 || imem_addr !== 32'h8) begin bad++; $display("FAIL t2_pre got=%h/%h exp=4/8", pc_out, imem_addr); end
    stall = 1'b1;
    tick();
    total++; if (pc_out !== 32'h4 || inst_valid !== 1'b1) begin bad++; $display("FAIL t2_hold got=%h/%h exp=4/1", pc_out, inst_valid); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t2_noreq got=%h exp=0", imem_req); end
    tick();
    total++; if (pc_out !== 32'h4 || imem_req !== 1'b0) begin bad++; $display("FAIL t2_hold2 got=%h/%h exp=4/0", pc_out, imem_req); end
    stall = 1'b0;
    tick();
    total++; if (pc_out !== 32'h8 || pc4_out !== 32'hC) begin bad++; $display("FAIL t2_skid got=%h/%h exp=8/c", pc_out, pc4_out); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin bad++; $display("FAIL t2_req got=%h/%h exp=1/c", imem_req, imem_addr); end
    tick();
    total++; if (pc_out !== 32'hC || inst_valid !== 1'b1) begin bad++; $display("FAIL t2_next got=%h/%h exp=c/1", pc_out, inst_valid); end
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc;
    logic        exp_v;
    br_valid = 1'b1; br_taken = 1'b0;
    br_pc4 = 32'h100; br_offset = 32'hFFFF_FFF0;
    tick();
    total++; if (pc_out !== 32'h10 || flush !== 1'b0) begin bad++; $display("FAIL t3_nt got=%h/%h exp=10/0", pc_out, flush); end
    total++; if (imem_addr !== 32'h14) begin bad++; $display("FAIL t3_nt_addr got=%h exp=14", imem_addr); end
    br_taken = 1'b1;
    tick();
`ifdef BRANCH_DELAY_SLOT_EN
    exp_v = 1'b1; exp_pc = 32'h10;
`else
    exp_v = 1'b0; exp_pc = 32'h10;
`endif
    total++; if (flush !== RFL) begin bad++; $display("FAIL t3_flush got=%h exp=%h", flush, RFL); end
    total++; if (inst_valid !== exp_v || pc_out !== exp_pc) begin bad++; $display("FAIL t3_vld got=%h/%h exp=%h/%h", inst_valid, pc_out, exp_v, exp_pc); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL t3_req got=%h exp=0", imem_req); end
    clr_redir(); imem_ack = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hF0) begin bad++; $display("FAIL t3_tgt got=%h/%h exp=1/f0", imem_req, imem_addr); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL t3_flush1 got=%h exp=0", flush); end
  endtask

  task automatic test_jump_vs_branch();
    jmp_valid = 1'b1; jmp_index = 26'h40;
    br_valid = 1'b1; br_taken = 1'b1;
    br_pc4 = 32'h1000_0004; br_offset = 32'h8;
    imem_ack = 1'b1;
    tick();
    total++; if (flush !== RFL) begin bad++; $display("FAIL t4_flush got=%h exp=%h", flush, RFL); end
    clr_redir(); imem_ack = 1'b0;
    tick();
    total++; if (imem_addr !== 32'h1000_0100 || imem_req !== 1'b1) begin bad++; $display("FAIL t4_tgt got=%h/%h exp=10000100/1", imem_addr, imem_req); end
  endtask

  task automatic test_drain();
    br_valid = 1'b1; br_taken = 1'b1;
    br_pc4 = 32'h200; br_offset = 32'h40;
    imem_ack = 1'b0;
    tick();
    total++; if (flush !== RFL || inst_valid !== 1'b0) begin bad++; $display("FAIL t5_redir got=%h/%h exp=%h/0", flush, inst_valid, RFL); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0100) begin bad++; $display("FAIL t5_hold0 got=%h/%h exp=1/10000100", imem_req, imem_addr); end
    clr_redir();
    tick(); tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000_0100) begin bad++; $display("FAIL t5_hold2 got=%h/%h exp=1/10000100", imem_req, imem_addr); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL t5_flush2 got=%h exp=0", flush); end
    imem_ack = 1'b1;
    tick();
    total++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL t5_disc got=%h/%h exp=0/0", inst_valid, imem_req); end
    imem_ack = 1'b0;
    tick();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h240) begin bad++; $display("FAIL t5_tgt got=%h/%h exp=1/240", imem_req, imem_addr); end
    imem_ack = 1'b1;
    tick();
    total++; if (pc_out !== 32'h240 || inst_valid !== 1'b1) begin bad++; $display("FAIL t5_out got=%h/%h exp=240/1", pc_out, inst_valid); end
  endtask

  task automatic test_back_to_back();
    imem_ack = 1'b0;
    br_valid = 1'b1; br_taken = 1'b1;
    br_pc4 = 32'h300; br_offset = 32'h0;
    tick();
    total++; if (flush !== RFL) begin bad++; $display("FAIL b2b_f1 got=%h exp=%h", flush, RFL); end
    br_valid = 1'b0; jmp_valid = 1'b1; jmp_index = 26'h80;
    tick();
    total++; if (flush !== RFL) begin bad++; $display("FAIL b2b_f2 got=%h exp=%h", flush, RFL); end
    total++; if (imem_addr !== 32'h244) begin bad++; $display("FAIL b2b_hold got=%h exp=244", imem_addr); end
    clr_redir(); imem_ack = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0 || flush !== 1'b0) begin bad++; $display("FAIL b2b_disc got=%h/%h exp=0/0", imem_req, flush); end
    imem_ack = 1'b0;
    tick();
    total++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin bad++; $display("FAIL b2b_tgt got=%h/%h exp=200/1", imem_addr, imem_req); end
  endtask

  task automatic test_wrap();
    br_valid = 1'b1; br_taken = 1'b1;
    br_pc4 = 32'hFFFF_FFF0; br_offset = 32'h20;
    imem_ack = 1'b1;
    tick();
    clr_redir(); imem_ack = 1'b0;
    tick();
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL wrap_br got=%h exp=10", imem_addr); end
    jmp_valid = 1'b1; jmp_index = 26'h3FF_FFFF; br_pc4 = 32'hF000_0000;
    imem_ack = 1'b1;
    tick();
    clr_redir(); imem_ack = 1'b0;
    tick();
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_jmp got=%h exp=fffffffc", imem_addr); end
    imem_ack = 1'b1;
    tick();
    total++; if (pc_out !== 32'hFFFF_FFFC || pc4_out !== 32'h0) begin bad++; $display("FAIL wrap_out got=%h/%h exp=fffffffc/0", pc_out, pc4_out); end
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL wrap_seq got=%h/%h exp=0/1", imem_addr, imem_req); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; imem_ack = 1'b1;
    br_valid = 1'b1; br_taken = 1'b1;
    tick();
    total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin bad++; $display("FAIL rmid got=%h/%h exp=0/0", imem_req, inst_valid); end
    total++; if (pc_out !== 32'h0 || flush !== 1'b0) begin bad++; $display("FAIL rmid_pc got=%h/%h exp=0/0", pc_out, flush); end
    rst = 1'b0; clr_redir();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ack = 1'b0;
    br_valid = 1'b0; br_taken = 1'b0;
    br_offset = '0; br_pc4 = '0;
    jmp_valid = 1'b0; jmp_index = '0;
    test_reset();
    test_stall_skid();
    test_branch();
    test_jump_vs_branch();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
